// File: rtl/sample_ram_ctrl.sv
// sample_ram_ctrl: QPI PSRAM init sequencer plus round-robin write/read arbiter for the sample RAM
//   clk_in, rst_n            : system clock, async active-low reset
//   ready                    : initialisation complete
//   wr_req/wr_addr/wr_data   : capture-path byte write, wr_ack pulses on completion
//   rd_req/rd_addr           : readback byte read, rd_data valid with rd_valid pulse
//   ram_io_out/oe/in         : nibble bus to the pads (tristates live at top level)
//   ram_clk, ram_cs_n        : PSRAM SCK and chip select
module sample_ram_ctrl #(
    parameter int ADDR_W    = 23,
    parameter int INIT_WAIT = 2048,
    parameter int DUMMY     = 6
) (
    input  logic              clk_in,
    input  logic              rst_n,
    output logic              ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [3:0]        ram_io_out,
    output logic [3:0]        ram_io_oe,
    input  logic [3:0]        ram_io_in,
    output logic              ram_clk,
    output logic              ram_cs_n
);
    typedef enum logic [3:0] {RST_WAIT, EXIT_QPI, DESEL, ENTER_QPI, IDLE, CMD, ADDR, WAIT, DATA} state_t;
    state_t      r_state, r_after;
    logic [31:0] r_cnt, r_sh;
    logic [7:0]  r_wdata;
    logic [3:0]  r_rd;
    logic        r_is_wr, r_last_wr;
    logic        w_gnt_wr, w_gnt_rd, w_last;
    // write wins unless both are pending and write had the previous grant
    assign w_gnt_wr = wr_req && (!rd_req || !r_last_wr);
    assign w_gnt_rd = rd_req && !w_gnt_wr;
    // final SCK cycle of the current phase
    always_comb w_last = (r_state == ENTER_QPI) ? (r_cnt == 7) :
                         (r_state == ADDR)      ? (r_cnt == 5) :
                         (r_state == WAIT)      ? (r_cnt == DUMMY - 1) : (r_cnt == 1);
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_WAIT;
            r_after    <= IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_is_wr    <= 1'b0;
            r_last_wr  <= 1'b0;
            ready      <= 1'b0;
            wr_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            ram_io_out <= '0;
            ram_io_oe  <= '0;
            ram_clk    <= 1'b0;
            ram_cs_n   <= 1'b1;
        end else begin
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                RST_WAIT: begin
                    r_cnt <= r_cnt + 1;
                    if (r_cnt == INIT_WAIT - 1) begin
                        r_cnt      <= '0;
                        r_state    <= EXIT_QPI;
                        ram_cs_n   <= 1'b0;
                        ram_io_oe  <= 4'hF;
                        ram_io_out <= 4'hF;
                        r_sh       <= 32'h5000_0000;
                    end
                end
                DESEL: begin
                    r_cnt <= r_cnt + 1;
                    if (r_cnt == 1) begin
                        r_cnt   <= '0;
                        r_state <= r_after;
                        ready   <= ready || (r_after == IDLE);
                        if (r_after == ENTER_QPI) begin
                            // 0x35 serial on io[0]: first bit now, remaining 7 left-aligned
                            ram_cs_n   <= 1'b0;
                            ram_io_oe  <= 4'h1;
                            ram_io_out <= 4'h0;
                            r_sh       <= 32'h6A00_0000;
                        end
                    end
                end
                IDLE: begin
                    if (w_gnt_wr || w_gnt_rd) begin
                        r_is_wr    <= w_gnt_wr;
                        r_last_wr  <= w_gnt_wr;
                        r_wdata    <= wr_data;
                        r_cnt      <= '0;
                        r_state    <= CMD;
                        ram_cs_n   <= 1'b0;
                        ram_io_oe  <= 4'hF;
                        ram_io_out <= w_gnt_wr ? 4'h3 : 4'hE;
                        r_sh       <= {w_gnt_wr ? 4'h8 : 4'hB, w_gnt_wr ? 24'(wr_addr) : 24'(rd_addr), 4'h0};
                    end
                end
                default: begin
                    ram_clk <= ~ram_clk;
                    // end of phase H: advance to the next nibble/bit
                    if (ram_clk) begin
                        r_cnt      <= w_last ? '0 : r_cnt + 1;
                        r_rd       <= ram_io_in;
                        r_sh       <= (r_state == ENTER_QPI) ? r_sh << 1 : r_sh << 4;
                        ram_io_out <= (r_state == ENTER_QPI) ? {3'b000, r_sh[31]} :
                                      (r_state == DATA && r_is_wr) ? r_wdata[3:0] : r_sh[31:28];
                        if (w_last && r_state == CMD) r_state <= ADDR;
                        if (w_last && r_state == WAIT) r_state <= DATA;
                        if (w_last && r_state == ADDR) begin
                            r_state    <= r_is_wr ? DATA : WAIT;
                            ram_io_out <= r_is_wr ? r_wdata[7:4] : 4'h0;
                            ram_io_oe  <= r_is_wr ? 4'hF : 4'h0;
                        end
                        if (w_last && (r_state inside {EXIT_QPI, ENTER_QPI, DATA})) begin
                            r_state    <= DESEL;
                            r_after    <= (r_state == EXIT_QPI) ? ENTER_QPI : IDLE;
                            ram_cs_n   <= 1'b1;
                            ram_io_oe  <= 4'h0;
                            ram_io_out <= 4'h0;
                        end
                        if (w_last && r_state == DATA) begin
                            wr_ack   <= r_is_wr;
                            rd_valid <= !r_is_wr;
                            if (!r_is_wr) rd_data <= {r_rd, ram_io_in};
                        end
                    end
                end
            endcase
        end
    end
endmodule
